pe_vec_pipe: RTL and testbench

- Parametrised, multi-lane successor to the single-lane pipelined PE.
- LANES independent lanes share one mode, handshake and pipeline.
- Adds two-stage pipelining, valid/ready backpressure, saturating adds, and a fourth mode (ACC) that accumulates internally per lane across a burst.
- Sits between the operand/weight buffers and the next array stage or the writeback FIFO.

---
 rtl/pe_vec_pipe.sv | 155 +++++++++++++++
 tb/tb_pe_vec_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_vec_pipe.sv
// rtl/pe_vec_pipe.sv - multi-lane two-stage saturating MAC/EWM/EWA/ACC processing element
module pe_vec_pipe #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] a_in,
  input  logic [LANES*DATA_WIDTH-1:0] b_in,
  input  logic [LANES*ACC_WIDTH-1:0]  acc_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  result_out,
  output logic [LANES-1:0]            sat_flag
);

  localparam logic [1:0] MODE_MAC = 2'b00;
  localparam logic [1:0] MODE_EWM = 2'b01;
  localparam logic [1:0] MODE_EWA = 2'b10;
  localparam logic [1:0] MODE_ACC = 2'b11;

  // Full product width and the one-bit-wider width used to detect overflow
  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = ACC_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic       w_stall;
  logic       w_adv;
  logic       w_emit;
  logic       r_s1_valid;
  logic       r_s1_last;
  logic [1:0] r_s1_mode;
  logic       r_out_valid;

  // The whole pipeline freezes while a result is presented but not taken
  assign w_stall   = r_out_valid & ~out_ready;
  assign w_adv     = ~w_stall;
  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;

  // Non-last ACC beats only update the accumulator and leave an empty output slot
  assign w_emit = r_s1_valid & ((r_s1_mode != MODE_ACC) | r_s1_last);

  // Shared control: stage-1 valid/mode/last and the output valid bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_mode   <= MODE_MAC;
      r_s1_last   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      r_out_valid <= w_emit;
      if (in_valid) begin
        r_s1_mode <= mode;
        r_s1_last <= in_last;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] w_a;
    logic signed [DATA_WIDTH-1:0] w_b;
    logic signed [PW-1:0]         w_prod_full;
    logic signed [DATA_WIDTH:0]   w_sum_ab;
    logic signed [ACC_WIDTH-1:0]  w_prod;
    logic signed [ACC_WIDTH-1:0]  w_ewa;
    logic signed [SW-1:0]         w_sum;
    logic                         w_clip;
    logic signed [ACC_WIDTH-1:0]  w_sat;
    logic signed [ACC_WIDTH-1:0]  r_prod;
    logic signed [ACC_WIDTH-1:0]  r_ewa;
    logic signed [ACC_WIDTH-1:0]  r_acc_in;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic                         r_sticky;
    logic signed [ACC_WIDTH-1:0]  r_res;
    logic                         r_sat;

    assign w_a = a_in[l*DATA_WIDTH +: DATA_WIDTH];
    assign w_b = b_in[l*DATA_WIDTH +: DATA_WIDTH];

    // Product keeps 2*FRAC_BITS fractional bits; the sum is realigned to match
    assign w_prod_full = PW'(w_a) * PW'(w_b);
    assign w_prod      = ACC_WIDTH'(w_prod_full);
    assign w_sum_ab    = (DATA_WIDTH+1)'(w_a) + (DATA_WIDTH+1)'(w_b);
    assign w_ewa       = ACC_WIDTH'(w_sum_ab) <<< FRAC_BITS;

    // Stage 1: capture per-lane products, realigned sum and partial sum on accept
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_prod   <= '0;
        r_ewa    <= '0;
        r_acc_in <= '0;
      end else if (w_adv && in_valid) begin
        r_prod   <= w_prod;
        r_ewa    <= w_ewa;
        r_acc_in <= acc_in[l*ACC_WIDTH +: ACC_WIDTH];
      end
    end

    // Stage 2: select the mode's sum one bit wider than the result
    always_comb begin
      w_sum = '0;
      case (r_s1_mode)
        MODE_MAC: w_sum = SW'(r_prod) + SW'(r_acc_in);
        MODE_EWM: w_sum = SW'(r_prod);
        MODE_EWA: w_sum = SW'(r_ewa);
        default:  w_sum = SW'(r_acc) + SW'(r_prod);
      endcase
    end

    // Overflow shows up as disagreement between the two top bits
    assign w_clip = w_sum[SW-1] ^ w_sum[SW-2];
    assign w_sat  = w_clip ? (w_sum[SW-1] ? SAT_MIN : SAT_MAX) : w_sum[ACC_WIDTH-1:0];

    // Per-lane accumulator and sticky flag, touched only by ACC beats
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_acc    <= '0;
        r_sticky <= 1'b0;
      end else if (w_adv && r_s1_valid && (r_s1_mode == MODE_ACC)) begin
        if (r_s1_last) begin
          r_acc    <= '0;
          r_sticky <= 1'b0;
        end else begin
          r_acc    <= w_sat;
          r_sticky <= r_sticky | w_clip;
        end
      end
    end

    // Output register: loaded only for beats that produce a result
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_res <= '0;
        r_sat <= 1'b0;
      end else if (w_adv && w_emit) begin
        r_res <= w_sat;
        r_sat <= w_clip | ((r_s1_mode == MODE_ACC) & r_sticky);
      end
    end

    assign result_out[l*ACC_WIDTH +: ACC_WIDTH] = r_res;
    assign sat_flag[l]                          = r_sat;
  end

endmodule

// File: tb/tb_pe_vec_pipe.sv
// tb/tb_pe_vec_pipe.sv - self-checking bench for pe_vec_pipe with a behavioural lane model
module tb_pe_vec_pipe;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int FB    = 8;
  localparam int RW    = LANES * AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic              in_last;
  logic [LANES*DW-1:0] a_in;
  logic [LANES*DW-1:0] b_in;
  logic [RW-1:0]     acc_in;
  logic              out_valid;
  logic              out_ready;
  logic [RW-1:0]     result_out;
  logic [LANES-1:0]  sat_flag;

  pe_vec_pipe #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .in_last(in_last), .a_in(a_in), .b_in(b_in), .acc_in(acc_in),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES-1:0] sat;
    logic [RW-1:0]    res;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;

  logic [DW-1:0] tva [LANES];
  logic [DW-1:0] tvb [LANES];
  logic [AW-1:0] tacc[LANES];
  logic [1:0]    tmode;
  bit            tlast;

  longint m_acc   [LANES];
  bit     m_sticky[LANES];

  logic [RW-1:0]    last_res;
  logic [LANES-1:0] last_sat;
  bit               was_stall;
  logic [RW-1:0]    hold_res;
  logic [LANES-1:0] hold_sat;

  task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic longint clamp(input longint x, output bit f);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -(longint'(1) <<< (AW - 1));
    f = 1'b0;
    if (x > mx) begin f = 1'b1; return mx; end
    if (x < mn) begin f = 1'b1; return mn; end
    return x;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int l = 0; l < LANES; l++) begin
      m_acc[l]    = 0;
      m_sticky[l] = 1'b0;
    end
    was_stall = 1'b0;
  endtask

  // Arithmetic reference: one accepted beat, in acceptance order
  task automatic model_accept();
    exp_t   e;
    bit     f;
    longint sa, sb, p, r;
    e = '0;
    for (int l = 0; l < LANES; l++) begin
      sa = longint'($signed(tva[l]));
      sb = longint'($signed(tvb[l]));
      p  = sa * sb;
      case (tmode)
        2'd0: r = clamp(p + longint'($signed(tacc[l])), f);
        2'd1: r = clamp(p, f);
        2'd2: r = clamp((sa + sb) * (longint'(1) <<< FB), f);
        default: begin
          r = clamp(m_acc[l] + p, f);
          m_sticky[l] = m_sticky[l] | f;
          f = m_sticky[l];
          m_acc[l] = r;
          if (tlast) begin
            m_acc[l]    = 0;
            m_sticky[l] = 1'b0;
          end
        end
      endcase
      e.res[l*AW +: AW] = r[AW-1:0];
      e.sat[l]          = f;
    end
    if (tmode != 2'd3 || tlast) exp_q.push_back(e);
  endtask

  task automatic drive_beat();
    for (int l = 0; l < LANES; l++) begin
      a_in[l*DW +: DW]   = tva[l];
      b_in[l*DW +: DW]   = tvb[l];
      acc_in[l*AW +: AW] = tacc[l];
    end
    mode    = tmode;
    in_last = tlast;
  endtask

  task automatic set_all(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] c);
    for (int l = 0; l < LANES; l++) begin
      tva[l]  = a;
      tvb[l]  = b;
      tacc[l] = c;
    end
  endtask

  task automatic rand_ops();
    for (int l = 0; l < LANES; l++) begin
      if ($urandom_range(0, 1) == 1) begin
        tva[l] = 16'($urandom);
        tvb[l] = 16'($urandom);
      end else begin
        tva[l] = 16'($urandom_range(0, 1023)) - 16'd512;
        tvb[l] = 16'($urandom_range(0, 1023)) - 16'd512;
      end
      case ($urandom_range(0, 3))
        0:       tacc[l] = 32'h7FFF_FFFF - 32'($urandom_range(0, 1 << 20));
        1:       tacc[l] = 32'h8000_0000 + 32'($urandom_range(0, 1 << 20));
        default: tacc[l] = 32'($urandom);
      endcase
    end
  endtask

  // One clock: drive, check the output side, account for an accept, advance
  task automatic tick(input bit v, input bit ordy, output bit acc_ok);
    exp_t e;
    in_valid  = v;
    out_ready = ordy;
    #1;
    if (was_stall) begin
      chk("hold_valid", RW'(out_valid), RW'(1'b1));
      chk("hold_result", result_out, hold_res);
      chk("hold_sat", RW'(sat_flag), RW'(hold_sat));
    end
    chk("in_ready", RW'(in_ready), RW'(!(out_valid && !ordy)));
    if (out_valid) begin
      chk("out_expected", RW'(exp_q.size() != 0), RW'(1'b1));
      if (ordy && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", result_out, e.res);
        chk("sat_flag", RW'(sat_flag), RW'(e.sat));
        last_res = result_out;
        last_sat = sat_flag;
        n_out++;
      end
    end
    was_stall = out_valid && !ordy;
    hold_res  = result_out;
    hold_sat  = sat_flag;
    acc_ok    = v && in_ready;
    if (acc_ok) model_accept();
    @(negedge clk);
  endtask

  task automatic send(input bit rnd_ready);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    drive_beat();
    while (!ok && n < 50) begin
      tick(1'b1, rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1, ok);
      n++;
    end
    chk("send_timeout", RW'(ok), RW'(1'b1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick(1'b0, 1'b1, ok);
      n++;
    end
    chk("drain_timeout", RW'(exp_q.size()), RW'(0));
  endtask

  initial begin
    bit ok;
    int n0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tmode     = 2'd0;
    tlast     = 1'b0;
    set_all('0, '0, '0);
    drive_beat();
    model_reset();
    last_res = '0;
    last_sat = '0;
    hold_res = '0;
    hold_sat = '0;

    #3;
    chk("rst_out_valid", RW'(out_valid), RW'(1'b0));
    chk("rst_result", result_out, RW'(0));
    chk("rst_sat", RW'(sat_flag), RW'(0));
    chk("rst_in_ready", RW'(in_ready), RW'(1'b1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // MAC on every lane, with the two-cycle latency checked explicitly
    tmode = 2'd0; tlast = 1'b0;
    set_all(16'h0180, 16'h0200, 32'h0001_0000);
    drive_beat();
    tick(1'b1, 1'b1, ok);
    chk("mac_accept", RW'(ok), RW'(1'b1));
    chk("mac_lat1", RW'(out_valid), RW'(1'b0));
    in_valid = 1'b0;
    tick(1'b0, 1'b1, ok);
    chk("mac_lat2", RW'(out_valid), RW'(1'b1));
    drain();
    for (int l = 0; l < LANES; l++) chk("mac_lane", RW'(last_res[l*AW +: AW]), RW'(32'h0004_0000));
    chk("mac_sat", RW'(last_sat), RW'(0));

    // EWM / EWA corner operands
    set_all('0, '0, '0);
    tmode = 2'd1; tva[0] = 16'h8000; tvb[0] = 16'h8000;
    send(1'b0); drain();
    chk("ewm_lane0", RW'(last_res[0 +: AW]), RW'(32'h4000_0000));
    chk("ewm_sat", RW'(last_sat), RW'(0));
    set_all('0, '0, '0);
    tmode = 2'd2; tva[1] = 16'h7FFF; tvb[1] = 16'h7FFF;
    send(1'b0); drain();
    chk("ewa_lane1", RW'(last_res[AW +: AW]), RW'(32'h00FF_FE00));
    chk("ewa1_sat", RW'(last_sat), RW'(0));
    set_all('0, '0, '0);
    tmode = 2'd2; tva[2] = 16'h0100; tvb[2] = 16'hFF00;
    send(1'b0); drain();
    chk("ewa_lane2", RW'(last_res[2*AW +: AW]), RW'(32'h0000_0000));
    chk("ewa2_sat", RW'(last_sat), RW'(0));

    // Saturation at both rails
    tmode = 2'd0;
    set_all(16'h0100, 16'h0100, 32'h7FFF_FFFF);
    send(1'b0); drain();
    chk("sat_hi_lane0", RW'(last_res[0 +: AW]), RW'(32'h7FFF_FFFF));
    chk("sat_hi_flag", RW'(last_sat), RW'(4'hF));
    set_all(16'hFF00, 16'h0100, 32'h8000_0000);
    send(1'b0); drain();
    chk("sat_lo_lane3", RW'(last_res[3*AW +: AW]), RW'(32'h8000_0000));
    chk("sat_lo_flag", RW'(last_sat), RW'(4'hF));

    // ACC group of four, then a fresh group of one
    n0 = n_out;
    tmode = 2'd3;
    set_all(16'h0100, 16'h0100, 32'h0);
    tlast = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0);
    tlast = 1'b1;
    send(1'b0);
    chk("acc_lat1", RW'(out_valid), RW'(1'b0));
    tick(1'b0, 1'b1, ok);
    chk("acc_lat2", RW'(out_valid), RW'(1'b1));
    drain();
    tick(1'b0, 1'b1, ok);
    chk("acc_one_output", RW'(n_out - n0), RW'(1));
    for (int l = 0; l < LANES; l++) chk("acc_lane", RW'(last_res[l*AW +: AW]), RW'(32'h0004_0000));
    chk("acc_sat", RW'(last_sat), RW'(0));
    send(1'b0); drain();
    chk("acc_cleared", RW'(last_res[0 +: AW]), RW'(32'h0001_0000));

    // Backpressure: three stalled cycles in the middle of six MAC beats
    n0 = n_out;
    tmode = 2'd0; tlast = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_ops(); send(1'b0); end
    rand_ops();
    drive_beat();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, ok);
      chk("bp_no_accept", RW'(ok), RW'(1'b0));
    end
    send(1'b0);
    for (int i = 0; i < 2; i++) begin rand_ops(); send(1'b0); end
    drain();
    chk("bp_count", RW'(n_out - n0), RW'(6));

    // Reset in the middle of an ACC group discards the partial sum
    tmode = 2'd3; tlast = 1'b0;
    set_all(16'h0100, 16'h0100, 32'h0);
    send(1'b0);
    send(1'b0);
    tick(1'b0, 1'b1, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", RW'(out_valid), RW'(1'b0));
    chk("mid_rst_result", result_out, RW'(0));
    chk("mid_rst_ready", RW'(in_ready), RW'(1'b1));
    model_reset();
    @(negedge clk);
    chk("mid_rst_valid2", RW'(out_valid), RW'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    tlast = 1'b1;
    send(1'b0); drain();
    for (int l = 0; l < LANES; l++) chk("rst_acc_lane", RW'(last_res[l*AW +: AW]), RW'(32'h0001_0000));

    // Randomised mixed-mode traffic with random gaps and random out_ready
    for (int i = 0; i < 300; i++) begin
      tmode = 2'($urandom_range(0, 3));
      tlast = ($urandom_range(0, 2) == 0);
      rand_ops();
      if ($urandom_range(0, 4) == 0) tick(1'b0, ($urandom_range(0, 3) != 0), ok);
      send(1'b1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
